// File: rtl/inc_halt_check_unit.sv
// Execution core of the 2-bit toy machine.
// Masks the raw instruction to NOP when the JNO logic disables it. Runs INC
// on a WIDTH-bit accumulator with a sticky overflow flag. A sticky HALT flag
// stops the program counter from stepping.
module inc_halt_check_unit #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       instr,
    input  logic             chk_en,
    output logic [1:0]       instr_checked,
    output logic [WIDTH-1:0] acc,
    output logic             status,
    output logic             halted,
    output logic             pc_step,
    output logic             inc_fire
);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_NOP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             status_q, status_d;
    logic             halted_q, halted_d;
    logic             fire_q,   fire_d;

    logic             inc_accept;
    logic [WIDTH:0]   sum_ext;

    // Qualify the instruction, decide INC acceptance and form the WIDTH+1 bit sum
    always_comb begin
        instr_checked = chk_en ? instr : OP_NOP;
        // An overflowed or halted machine ignores INC, so acc stays frozen
        inc_accept    = (instr_checked == OP_INC) && !status_q && !halted_q;
        sum_ext       = {1'b0, acc_q} + {{WIDTH{1'b0}}, 1'b1};
        // The HALT opcode itself must not advance the PC
        pc_step       = !halted_q && (instr_checked != OP_HALT);
    end

    // Next-state logic. Status and halt only ever accumulate; only reset clears them
    always_comb begin
        acc_d    = acc_q;
        status_d = status_q;
        halted_d = halted_q;
        fire_d   = 1'b0;
        if (inc_accept) begin
            acc_d    = sum_ext[WIDTH-1:0];
            status_d = status_q | sum_ext[WIDTH];
            fire_d   = 1'b1;
        end
        if (instr_checked == OP_HALT) begin
            halted_d = 1'b1;
        end
    end

    // State registers. Reset has priority over any instruction in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            status_q <= 1'b0;
            halted_q <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            status_q <= status_d;
            halted_q <= halted_d;
            fire_q   <= fire_d;
        end
    end

    assign acc      = acc_q;
    assign status   = status_q;
    assign halted   = halted_q;
    assign inc_fire = fire_q;

endmodule

// File: tb/tb_inc_halt_check_unit.sv
// Bench for inc_halt_check_unit. Runs the directed plan first, then random
// instructions with occasional resets. Every result is compared against a
// behavioural model of the machine.
module tb_inc_halt_check_unit;

    localparam int WIDTH = 2;
    localparam int ACC_MAX = (1 << WIDTH) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       instr = 2'b00;
    logic             chk_en = 1'b1;
    logic [1:0]       instr_checked;
    logic [WIDTH-1:0] acc;
    logic             status, halted, pc_step, inc_fire;

    int n_checks = 0;
    int n_errors = 0;

    // Model state. It is valid only after the first reset
    int m_acc = 0;
    bit m_status = 0, m_halted = 0, m_fire = 0, m_known = 0;

    inc_halt_check_unit #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .instr(instr), .chk_en(chk_en),
        .instr_checked(instr_checked), .acc(acc), .status(status),
        .halted(halted), .pc_step(pc_step), .inc_fire(inc_fire)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One machine cycle: drive inputs, check the combinational outputs, clock,
    // update the model, then check the registered state.
    task automatic step(input bit rst, input logic [1:0] ins, input bit en);
        int qi;
        @(negedge clock);
        reset = rst; instr = ins; chk_en = en;
        #1;
        qi = en ? int'(ins) : 2;
        chk("instr_checked", {30'd0, instr_checked}, qi);
        if (m_known)
            chk("pc_step", {31'd0, pc_step}, {31'd0, (!m_halted && qi != 3)});
        @(posedge clock);
        if (rst) begin
            m_acc = 0; m_status = 0; m_halted = 0; m_fire = 0; m_known = 1;
        end else begin
            m_fire = 0;
            if (qi == 0 && !m_status && !m_halted) begin
                m_fire = 1;
                if (m_acc == ACC_MAX) begin
                    m_acc = 0; m_status = 1;
                end else begin
                    m_acc = m_acc + 1;
                end
            end
            if (qi == 3) m_halted = 1;
        end
        #1;
        chk("acc", {{(32-WIDTH){1'b0}}, acc}, m_acc);
        chk("status", {31'd0, status}, {31'd0, m_status});
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("inc_fire", {31'd0, inc_fire}, {31'd0, m_fire});
    endtask

    initial begin
        // Reset for two edges
        step(1, 2'b00, 1);
        step(1, 2'b00, 1);
        chk("reset_acc_const", {30'd0, acc}, 0);
        chk("reset_pcstep_const", {31'd0, pc_step}, 1);
        // Count 01, 10, 11, then wrap with overflow, then sticky
        for (int i = 0; i < 3; i++) step(0, 2'b00, 1);
        chk("count_acc_const", {30'd0, acc}, 3);
        step(0, 2'b00, 1);
        chk("wrap_status_const", {31'd0, status}, 1);
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        chk("frozen_fire_const", {31'd0, inc_fire}, 0);
        // Masking: a raw HALT under chk_en=0 must not halt
        step(1, 2'b00, 1);
        step(0, 2'b00, 0);
        step(0, 2'b11, 0);
        chk("mask_halted_const", {31'd0, halted}, 0);
        // Halt, then an INC that must be ignored
        step(0, 2'b00, 1);
        step(0, 2'b11, 1);
        step(0, 2'b00, 1);
        chk("halt_acc_const", {30'd0, acc}, 1);
        chk("halt_pcstep_const", {31'd0, pc_step}, 0);
        // Reset wins over INC while halted, then execution resumes
        step(1, 2'b00, 1);
        step(0, 2'b00, 1);
        chk("resume_acc_const", {30'd0, acc}, 1);
        // Random run
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
